// File: rtl/mips_pkg.sv
// Shared MIPS datapath types for the HI/LO multiply/divide writer.
//   muldiv_op_t    : op encoding on the 3-bit op bus (6 and 7 are no-ops)
//   regwrite_t     : single_reg-style 2-bit write enable
//   muldiv_state_t : sequencer states
package mips_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } muldiv_op_t;

   typedef logic [1:0] regwrite_t;

   localparam regwrite_t REGWRITE_EN  = 2'b11;
   localparam regwrite_t REGWRITE_OFF = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      WRITE
   } muldiv_state_t;

endpackage

// File: rtl/hilo_muldiv_writer_if.sv
// Issue/write-back bundle between the control unit / register file and the
// HI/LO multiply/divide writer.
//   master : control side, drives start/op/rs_data/rt_data, observes results
//   slave  : the muldiv unit, drives busy and the HI/LO write ports
interface hilo_muldiv_writer_if #(
   parameter int unsigned WIDTH = 32
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             busy;
   logic [1:0]       hi_write;
   logic [1:0]       lo_write;
   logic [WIDTH-1:0] hi_data;
   logic [WIDTH-1:0] lo_data;

   modport master (
      output start, op, rs_data, rt_data,
      input  busy, hi_write, lo_write, hi_data, lo_data
   );

   modport slave (
      input  start, op, rs_data, rt_data,
      output busy, hi_write, lo_write, hi_data, lo_data
   );

endinterface

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
//   is_div  : 0 = radix-2 shift-add multiply step, 1 = restoring divide step
//   acc_in  : 2*WIDTH accumulator (mul: partial product | multiplier,
//             div: partial remainder | dividend/quotient)
//   operand : multiplicand magnitude or divisor magnitude
//   acc_out : accumulator after this iteration
module muldiv_iter_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   always_comb begin
      // Multiply: add multiplicand into the high half when the current
      // multiplier bit is set, keep the carry, then shift right by one.
      sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      // Divide: the partial remainder with the next dividend bit shifted in
      // is exactly acc_in[2W-1:W-1]; the trial subtract's borrow lands in
      // diff[WIDTH], and the whole accumulator shifts left by one.
      rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, operand};
      if (is_div) begin
         if (diff[WIDTH]) begin
            acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end else begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv_writer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit driving the write side of
// the HI and LO registers.
//   clk, reset : clock, synchronous active-high reset
//   bus.start  : issue strobe, only honoured while idle
//   bus.op     : operation (see muldiv_op_t); 6/7 are ignored
//   bus.rs_data/rt_data : operands (rs is also the MTHI/MTLO source)
//   bus.busy   : high whenever an operation is in flight
//   bus.hi_write/lo_write : 2'b11 for the single WRITE cycle, else 2'b00
//   bus.hi_data/lo_data   : registered write data, held between writes
// CNT_W must satisfy 2**CNT_W > WIDTH.
module hilo_muldiv_writer
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input logic                 clk,
   input logic                 reset,
   hilo_muldiv_writer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   muldiv_state_t      state;
   muldiv_op_t         op_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   src;
   logic               neg_q;
   logic               rneg_q;
   logic               dz_q;
   logic               busy_q;
   regwrite_t          hi_we_q;
   regwrite_t          lo_we_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               is_div;
   logic               issue_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      is_div       = (op_q == DIV) || (op_q == DIVU);
      issue_signed = (bus.op == MULT) || (bus.op == DIV);
      // Two's-complement magnitude; the most negative value maps to 2**(W-1).
      a_mag = (issue_signed && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
      b_mag = (issue_signed && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
   end

   // Multiplicand and divisor both occupy opnd, and both start with the
   // rs magnitude in the low half of acc, so issue is op-independent.
   muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (acc),
      .operand (opnd),
      .acc_out (acc_nxt)
   );

   // Sign fix applied to the final iteration's result.
   always_comb begin
      prod_fix = neg_q ? -acc_nxt : acc_nxt;
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (dz_q) begin
            fix_lo = '1;
            fix_hi = src;
         end else begin
            fix_lo = neg_q  ? -acc_nxt[WIDTH-1:0]       : acc_nxt[WIDTH-1:0];
            fix_hi = rneg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         op_q    <= MULT;
         cnt     <= '0;
         acc     <= '0;
         opnd    <= '0;
         src     <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_we_q <= REGWRITE_OFF;
         lo_we_q <= REGWRITE_OFF;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     MULT, MULTU, DIV, DIVU: begin
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opnd   <= b_mag;
                        src    <= bus.rs_data;
                        op_q   <= muldiv_op_t'(bus.op);
                        neg_q  <= issue_signed & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                        rneg_q <= issue_signed & bus.rs_data[WIDTH-1];
                        dz_q   <= (bus.rt_data == '0);
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                     end
                     MTHI: begin
                        src     <= bus.rs_data;
                        op_q    <= MTHI;
                        hi_q    <= bus.rs_data;
                        hi_we_q <= REGWRITE_EN;
                        busy_q  <= 1'b1;
                        state   <= WRITE;
                     end
                     MTLO: begin
                        src     <= bus.rs_data;
                        op_q    <= MTLO;
                        lo_q    <= bus.rs_data;
                        lo_we_q <= REGWRITE_EN;
                        busy_q  <= 1'b1;
                        state   <= WRITE;
                     end
                     default: begin
                     end
                  endcase
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_ITER) begin
                  hi_q    <= fix_hi;
                  lo_q    <= fix_lo;
                  hi_we_q <= REGWRITE_EN;
                  lo_we_q <= REGWRITE_EN;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               hi_we_q <= REGWRITE_OFF;
               lo_we_q <= REGWRITE_OFF;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               hi_we_q <= REGWRITE_OFF;
               lo_we_q <= REGWRITE_OFF;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.hi_write = hi_we_q;
   assign bus.lo_write = lo_we_q;
   assign bus.hi_data  = hi_q;
   assign bus.lo_data  = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_writer.sv
// Self-checking bench for hilo_muldiv_writer: expected HI/LO writes are
// pushed to a queue at issue time and popped by a monitor whenever the DUT
// asserts a write enable; tasks check busy duration and write timing.
module tb_hilo_muldiv_writer;
   import mips_pkg::*;

   typedef struct packed {
      logic [1:0]  hw;
      logic [1:0]  lw;
      logic [31:0] hd;
      logic [31:0] ld;
   } wr_t;

   logic clk = 1'b0;
   logic reset;

   hilo_muldiv_writer_if #(.WIDTH(32)) bus ();

   hilo_muldiv_writer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   wr_t  sb_q[$];
   wr_t  mon_e;
   int   vectors     = 0;
   int   miscompares = 0;
   logic mon_en      = 1'b0;

   function automatic wr_t model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      wr_t         e;
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      e  = '0;
      sa = longint'($signed(rs));
      sb = longint'($signed(rt));
      case (op)
         3'd0: begin
            p = sa * sb;
            e.hw = 2'b11; e.lw = 2'b11; e.hd = p[63:32]; e.ld = p[31:0];
         end
         3'd1: begin
            p = {32'b0, rs} * {32'b0, rt};
            e.hw = 2'b11; e.lw = 2'b11; e.hd = p[63:32]; e.ld = p[31:0];
         end
         3'd2: begin
            e.hw = 2'b11; e.lw = 2'b11;
            if (rt == 32'd0) begin
               e.ld = 32'hFFFF_FFFF; e.hd = rs;
            end else begin
               q = sa / sb; r = sa % sb;
               e.ld = q[31:0]; e.hd = r[31:0];
            end
         end
         3'd3: begin
            e.hw = 2'b11; e.lw = 2'b11;
            if (rt == 32'd0) begin
               e.ld = 32'hFFFF_FFFF; e.hd = rs;
            end else begin
               e.ld = rs / rt; e.hd = rs % rt;
            end
         end
         3'd4: begin e.hw = 2'b11; e.hd = rs; end
         3'd5: begin e.lw = 2'b11; e.ld = rs; end
         default: begin end
      endcase
      return e;
   endfunction

   // Scoreboard consumer: every cycle with any write enable must match the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      if (mon_en && (bus.hi_write !== 2'b00 || bus.lo_write !== 2'b00)) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write got hw=%b lw=%b hi=%h lo=%h required no write",
                     bus.hi_write, bus.lo_write, bus.hi_data, bus.lo_data);
         end else begin
            mon_e = sb_q.pop_front();
            if (bus.hi_write !== mon_e.hw || bus.lo_write !== mon_e.lw ||
                (mon_e.hw == 2'b11 && bus.hi_data !== mon_e.hd) ||
                (mon_e.lw == 2'b11 && bus.lo_data !== mon_e.ld)) begin
               miscompares++;
               $display("FAIL write_result got hw=%b lw=%b hi=%h lo=%h required hw=%b lw=%b hi=%h lo=%h",
                        bus.hi_write, bus.lo_write, bus.hi_data, bus.lo_data,
                        mon_e.hw, mon_e.lw, mon_e.hd, mon_e.ld);
            end
         end
      end
   end

   // Drives start for one cycle; returns at the negedge inside cycle 1.
   task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = rs;
      bus.rt_data = rt;
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   // Measures busy cycles and the first write cycle (1-based from the call).
   task automatic wait_idle(output int busy_cyc, output int wr_cyc);
      busy_cyc = 0;
      wr_cyc   = 0;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         if ((bus.hi_write !== 2'b00 || bus.lo_write !== 2'b00) && wr_cyc == 0) wr_cyc = cyc;
         if (bus.busy !== 1'b1) break;
         busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.op      = 3'd0;
      bus.rs_data = '0;
      bus.rt_data = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi_write !== 2'b00 || bus.lo_write !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ctrl got busy=%b hw=%b lw=%b required 0/00/00", bus.busy, bus.hi_write, bus.lo_write);
      end
      vectors++;
      if (bus.hi_data !== 32'd0 || bus.lo_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_data got hi=%h lo=%h required 0/0", bus.hi_data, bus.lo_data);
      end
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_multu_max();
      int bc;
      int wc;
      sb_q.push_back(model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(bc, wc);
      vectors++;
      if (bc !== 33) begin miscompares++; $display("FAIL multu_busy got %0d required 33", bc); end
      vectors++;
      if (wc !== 33) begin miscompares++; $display("FAIL multu_write_cycle got %0d required 33", wc); end
      vectors++;
      if (sb_q.size() !== 0) begin miscompares++; $display("FAIL multu_pending got %0d required 0", sb_q.size()); end
   endtask

   task automatic test_arith();
      logic [2:0]  ops [8] = '{3'd0, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd0, 3'd3};
      logic [31:0] rss [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] rts [8] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF,
                               32'd0, 32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000};
      int bc;
      int wc;
      for (int i = 0; i < 14; i++) begin
         logic [2:0]  op;
         logic [31:0] rs;
         logic [31:0] rt;
         if (i < 8) begin
            op = ops[i]; rs = rss[i]; rt = rts[i];
         end else begin
            op = 3'($urandom_range(0, 3));
            rs = $urandom;
            rt = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         end
         sb_q.push_back(model(op, rs, rt));
         issue(op, rs, rt);
         wait_idle(bc, wc);
         vectors++;
         if (bc !== 33 || wc !== 33) begin
            miscompares++;
            $display("FAIL arith_timing[%0d] op=%0d got busy=%0d wr=%0d required 33/33", i, op, bc, wc);
         end
      end
      vectors++;
      if (sb_q.size() !== 0) begin miscompares++; $display("FAIL arith_pending got %0d required 0", sb_q.size()); end
   endtask

   task automatic test_move();
      int bc;
      int wc;
      sb_q.push_back(model(3'd5, 32'h1234_5678, 32'hDEAD_BEEF));
      issue(3'd5, 32'h1234_5678, 32'hDEAD_BEEF);
      wait_idle(bc, wc);
      vectors++;
      if (bc !== 1 || wc !== 1) begin miscompares++; $display("FAIL mtlo_timing got busy=%0d wr=%0d required 1/1", bc, wc); end
      sb_q.push_back(model(3'd4, 32'hA5A5_0F0F, 32'h0));
      issue(3'd4, 32'hA5A5_0F0F, 32'h0);
      wait_idle(bc, wc);
      vectors++;
      if (bc !== 1 || wc !== 1) begin miscompares++; $display("FAIL mthi_timing got busy=%0d wr=%0d required 1/1", bc, wc); end
      @(negedge clk);
      vectors++;
      if (bus.hi_data !== 32'hA5A5_0F0F || bus.lo_data !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL move_hold got hi=%h lo=%h required a5a50f0f/12345678", bus.hi_data, bus.lo_data);
      end
      vectors++;
      if (sb_q.size() !== 0) begin miscompares++; $display("FAIL move_pending got %0d required 0", sb_q.size()); end
   endtask

   task automatic test_noop();
      for (int k = 6; k <= 7; k++) begin
         issue(3'(k), 32'h1111_1111, 32'h2222_2222);
         for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL noop_busy op=%0d got %b required 0", k, bus.busy); end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int bc;
      int wc;
      sb_q.push_back(model(3'd1, 32'h0001_2345, 32'h0000_6789));
      issue(3'd1, 32'h0001_2345, 32'h0000_6789);
      repeat (4) @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = 3'd3;
      bus.rs_data = 32'd1000;
      bus.rt_data = 32'd7;
      @(negedge clk);
      bus.start   = 1'b0;
      wait_idle(bc, wc);
      vectors++;
      if (bc !== 28 || wc !== 28) begin
         miscompares++;
         $display("FAIL busy_start_timing got busy=%0d wr=%0d required 28/28", bc, wc);
      end
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_late got busy=%b required 0", bus.busy); end
      end
      vectors++;
      if (sb_q.size() !== 0) begin miscompares++; $display("FAIL busy_start_pending got %0d required 0", sb_q.size()); end
   endtask

   task automatic test_reset_abort();
      int bc;
      int wc;
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi_write !== 2'b00 || bus.lo_write !== 2'b00) begin
         miscompares++;
         $display("FAIL abort_ctrl got busy=%b hw=%b lw=%b required 0/00/00", bus.busy, bus.hi_write, bus.lo_write);
      end
      vectors++;
      if (bus.hi_data !== 32'd0 || bus.lo_data !== 32'd0) begin
         miscompares++;
         $display("FAIL abort_data got hi=%h lo=%h required 0/0", bus.hi_data, bus.lo_data);
      end
      reset = 1'b0;
      repeat (30) @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_resume got busy=%b required 0", bus.busy); end
      sb_q.push_back(model(3'd1, 32'd3, 32'd4));
      issue(3'd1, 32'd3, 32'd4);
      wait_idle(bc, wc);
      vectors++;
      if (bc !== 33 || wc !== 33) begin
         miscompares++;
         $display("FAIL post_abort_timing got busy=%0d wr=%0d required 33/33", bc, wc);
      end
      vectors++;
      if (sb_q.size() !== 0) begin miscompares++; $display("FAIL post_abort_pending got %0d required 0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_arith();
      test_move();
      test_noop();
      test_start_while_busy();
      test_reset_abort();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
